// File: rtl/baud_rate_generator_pkg.sv
// -----------------------------------------------------------------------------
// baud_rate_generator_pkg
//   Shared UART constants: default divisor width and standard divisor values
//   for a 100 MHz system clock with 16x oversampling.
//   Divisor rule: divsr = round(Fclk / (16 * baud)) - 1.
// -----------------------------------------------------------------------------
package baud_rate_generator_pkg;

    // Default width of the divisor input and of the internal counter.
    localparam int DVSR_WIDTH_DEF = 11;

    // Standard divisors for a 100 MHz clock (tick = 16x baud).
    localparam logic [10:0] DVSR_9600_100MHZ   = 11'd650;
    localparam logic [10:0] DVSR_19200_100MHZ  = 11'd325;
    localparam logic [10:0] DVSR_115200_100MHZ = 11'd53;

    // Rounded divisor for an arbitrary clock/baud pair. The 8*baud term
    // rounds the division to nearest instead of truncating.
    function automatic int calc_dvsr(input int fclk_hz, input int baud);
        calc_dvsr = ((fclk_hz + (32'sd8 * baud)) / (32'sd16 * baud)) - 32'sd1;
    endfunction

endpackage : baud_rate_generator_pkg

// File: rtl/baud_rate_generator.sv
// -----------------------------------------------------------------------------
// baud_rate_generator
//   Programmable clock-enable generator for the UART. Divides clk by
//   (divsr+1) and emits a one-cycle tick at 16x the serial bit rate; tick
//   feeds s_tick of the UART transmitter and receiver.
//
// Ports
//   clk    in   1           system clock, rising edge
//   reset  in   1           synchronous, active-high reset
//   divsr  in   DVSR_WIDTH  divisor; tick period is divsr+1 clk cycles
//   tick   out  1           one-clk-wide pulse, registered
// -----------------------------------------------------------------------------
module baud_rate_generator
    import baud_rate_generator_pkg::*;
#(
    parameter int DVSR_WIDTH = DVSR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DVSR_WIDTH-1:0] divsr,
    output logic                  tick
);

    logic [DVSR_WIDTH-1:0] cnt_r;
    logic [DVSR_WIDTH-1:0] cnt_next_s;
    logic                  tick_r;
    logic                  tick_next_s;

    // Next counter/tick values. The compare is >= so that lowering divsr
    // below the current count wraps on the next edge instead of letting the
    // counter run all the way round; the wrap at cnt==divsr also means the
    // all-ones divisor never overflows the increment.
    always_comb begin
        cnt_next_s  = {DVSR_WIDTH{1'b0}};
        tick_next_s = 1'b0;
        if (cnt_r >= divsr) begin
            cnt_next_s  = {DVSR_WIDTH{1'b0}};
            tick_next_s = 1'b1;
        end else begin
            cnt_next_s  = cnt_r + {{(DVSR_WIDTH-1){1'b0}}, 1'b1};
            tick_next_s = 1'b0;
        end
    end

    // Counter and tick registers; reset has priority over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= {DVSR_WIDTH{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            tick_r <= tick_next_s;
        end
    end

    assign tick = tick_r;

endmodule : baud_rate_generator

// File: tb/tb_baud_rate_generator.sv
// -----------------------------------------------------------------------------
// tb_baud_rate_generator
//   Self-checking bench for baud_rate_generator: a per-cycle vector table for
//   short divisors plus hand-written sequences for the long-period cases.
// -----------------------------------------------------------------------------
module tb_baud_rate_generator;
    import baud_rate_generator_pkg::*;

    localparam int W = DVSR_WIDTH_DEF;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] divsr = DVSR_9600_100MHZ;
    logic         tick;

    int n_cmp  = 0;
    int n_fail = 0;

    baud_rate_generator #(.DVSR_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .divsr (divsr),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [W-1:0] dv;
        logic         exp_tick;
        logic [W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges until tick is seen high; -1 if the budget runs out.
    task automatic wait_tick(input int budget, output int edges);
        edges = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (tick === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        reset = 1'b0;
    endtask

    initial begin
        int e;
        int nt;
        int first;

        // ---------------- vector table ----------------
        // Reset held with divsr=650.
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b1, 11'd650, 1'b0, 11'd0});
        // divsr=0: tick every cycle, cnt stuck at 0.
        for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 11'd0, 1'b1, 11'd0});
        // divsr=1: tick alternates 0,1.
        vecs.push_back('{1'b1, 11'd1, 1'b0, 11'd0});
        vecs.push_back('{1'b0, 11'd1, 1'b0, 11'd1});
        vecs.push_back('{1'b0, 11'd1, 1'b1, 11'd0});
        vecs.push_back('{1'b0, 11'd1, 1'b0, 11'd1});
        vecs.push_back('{1'b0, 11'd1, 1'b1, 11'd0});
        // divsr=3: period 4.
        vecs.push_back('{1'b1, 11'd3, 1'b0, 11'd0});
        vecs.push_back('{1'b0, 11'd3, 1'b0, 11'd1});
        vecs.push_back('{1'b0, 11'd3, 1'b0, 11'd2});
        vecs.push_back('{1'b0, 11'd3, 1'b0, 11'd3});
        vecs.push_back('{1'b0, 11'd3, 1'b1, 11'd0});
        vecs.push_back('{1'b0, 11'd3, 1'b0, 11'd1});
        // divsr=5, lowered to 1 while cnt=3: immediate wrap.
        vecs.push_back('{1'b1, 11'd5, 1'b0, 11'd0});
        vecs.push_back('{1'b0, 11'd5, 1'b0, 11'd1});
        vecs.push_back('{1'b0, 11'd5, 1'b0, 11'd2});
        vecs.push_back('{1'b0, 11'd5, 1'b0, 11'd3});
        vecs.push_back('{1'b0, 11'd1, 1'b1, 11'd0});
        vecs.push_back('{1'b0, 11'd1, 1'b0, 11'd1});
        vecs.push_back('{1'b0, 11'd1, 1'b1, 11'd0});
        // Reset mid-count with divsr=3.
        vecs.push_back('{1'b0, 11'd3, 1'b0, 11'd1});
        vecs.push_back('{1'b1, 11'd3, 1'b0, 11'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            divsr = vecs[i].dv;
            step();
            check($sformatf("vec%0d_tick", i), {31'd0, tick}, {31'd0, vecs[i].exp_tick});
            check($sformatf("vec%0d_cnt", i), {21'd0, dut.cnt_r}, {21'd0, vecs[i].exp_cnt});
        end

        // ---------------- divsr=650: first tick and 20 periods ----------------
        divsr = DVSR_9600_100MHZ;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst650_tick", {31'd0, tick}, 32'd0);
            check("rst650_cnt", {21'd0, dut.cnt_r}, 32'd0);
        end
        reset = 1'b0;
        wait_tick(700, e);
        check("first_tick_650", e, 32'd651);
        for (int p = 0; p < 20; p++) begin
            wait_tick(700, e);
            check($sformatf("period650_%0d", p), e, 32'd651);
        end

        // ---------------- lower divsr at cnt=400 ----------------
        divsr = 11'd650;
        do_reset(2);
        for (int i = 0; i < 400; i++) step();
        check("cnt_at_400", {21'd0, dut.cnt_r}, 32'd400);
        check("no_tick_at_400", {31'd0, tick}, 32'd0);
        divsr = 11'd100;
        wait_tick(700, e);
        check("wrap_after_lower", e, 32'd1);
        wait_tick(700, e);
        check("period101_a", e, 32'd101);
        wait_tick(700, e);
        check("period101_b", e, 32'd101);

        // ---------------- reset 300 cycles into a period ----------------
        divsr = 11'd650;
        do_reset(2);
        for (int i = 0; i < 300; i++) step();
        check("cnt_at_300", {21'd0, dut.cnt_r}, 32'd300);
        reset = 1'b1;
        step();
        check("midrst_tick", {31'd0, tick}, 32'd0);
        check("midrst_cnt", {21'd0, dut.cnt_r}, 32'd0);
        reset = 1'b0;
        wait_tick(700, e);
        check("tick_after_midrst", e, 32'd651);

        // ---------------- divsr all ones ----------------
        divsr = 11'h7FF;
        do_reset(2);
        nt    = 0;
        first = -1;
        for (int i = 1; i <= 10000; i++) begin
            step();
            if (tick === 1'b1) begin
                nt++;
                if (first < 0) first = i;
            end
        end
        check("max_first_tick", first, 32'd2048);
        check("max_tick_count", nt, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_baud_rate_generator
